serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 38 +++
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders plus an OR of their carries.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha1 (
        .a (s1),
        .b (cin),
        .s (sum),
        .c (c2)
    );

    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts an operand pair, adds one bit per cycle LSB first,
// then presents sum/carry until the consumer takes them.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow port ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_sr;   // operand A shifting out, sum bits shifting in
    logic [WIDTH-1:0] b_sr;
    logic             cy_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    assign last_bit  = (cnt == LAST_BIT);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    full_adder u_fa (
        .a    (acc_sr[0]),
        .b    (b_sr[0]),
        .cin  (cy_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, WIDTH bit steps in SHIFT, hold in DONE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: operand load, per-bit add/shift, result capture on the last bit.
    // The A register doubles as the result register: each sum bit enters at the
    // MSB as the consumed operand bit leaves at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_sr <= '0;
            b_sr   <= '0;
            cy_q   <= 1'b0;
            sum    <= '0;
            carry  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc_sr <= a;
                        b_sr   <= b;
                        cy_q   <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    acc_sr <= {fa_sum, acc_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    cy_q   <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum   <= {fa_sum, acc_sr[WIDTH-1:1]};
                        carry <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB (carry flop on the last step) XOR carry out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ovf <= 1'b0;
        else if (state == SHIFT && last_bit) ovf <= cy_q ^ fa_cout;
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, corner-case
// sequences, and randomized operands against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_carry;
        logic         exp_ovf;
    } vec_t;

    int unsigned  n_vec;
    int unsigned  n_err;
    logic [W-1:0] last_sum;
    logic         last_carry;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand pair
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        int unsigned total;
        total = int'(ma) + int'(mb);
        es = W'(total % (1 << W));
        ec = (total >= (1 << W));
        eo = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
    endtask

    // One full transaction: present operands, measure latency, optionally
    // inject ignored stimulus, stall in DONE, check result, release.
    task automatic transact(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic [W-1:0] es, input logic ec, input logic eo,
                            input int unsigned stall, input bit inject, input string tag);
        int unsigned n;
        bit          hold_ok;
        bit          stable_ok;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a_i = ta; b_i = tb;
        @(posedge clk); #1;
        in_valid = 1'b0; a_i = W'($urandom); b_i = W'($urandom);
        n = 0;
        hold_ok = 1'b1;
        if (sum !== last_sum || carry !== last_carry) hold_ok = 1'b0;
        while (!out_valid && n < 4 * W) begin
            if (inject && n == 2) begin
                in_valid = 1'b1; a_i = 8'h55; b_i = 8'h55; out_ready = 1'b1;
            end else begin
                in_valid = 1'b0; out_ready = 1'b0;
            end
            @(posedge clk); #1; n++;
            if (!out_valid && (sum !== last_sum || carry !== last_carry)) hold_ok = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check({tag, ".latency"}, n, W);
        check({tag, ".hold_prev"}, 32'(hold_ok), 32'd1);
        check({tag, ".sum"}, 32'(sum), 32'(es));
        check({tag, ".carry"}, 32'(carry), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
        stable_ok = 1'b1;
        for (int unsigned s = 0; s < stall; s++) begin
            if (inject) begin in_valid = 1'b1; a_i = 8'h55; end
            @(posedge clk); #1;
            if (!out_valid || sum !== es || carry !== ec) stable_ok = 1'b0;
        end
        check({tag, ".stall_stable"}, 32'(stable_ok), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".release"}, {30'd0, out_valid, in_ready}, 32'b01);
        in_valid = 1'b0;
        last_sum   = es;
        last_carry = ec;
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           quiet;

        n_vec = 0; n_err = 0;
        last_sum = '0; last_carry = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;

        vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

        #12;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.carry", 32'(carry), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset.ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors
        for (int i = 0; i < 8; i++)
            transact(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_carry,
                     vecs[i].exp_ovf, 0, 1'b0, $sformatf("vec%0d", i));

        // Long stall in DONE
        transact(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 5, 1'b0, "stall5");

        // in_valid pulsed with other operands during SHIFT and during DONE
        transact(8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 3, 1'b1, "ignore");

        // Reset at bit 4 of 0xAA+0x55
        in_valid = 1'b1; a_i = 8'hAA; b_i = 8'h55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3; rst_n = 1'b0; #1;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.sum", 32'(sum), 32'd0);
        check("midrst.carry", 32'(carry), 32'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        last_sum = '0; last_carry = 1'b0;
        quiet = 1'b1;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (out_valid || sum !== 8'h00 || !in_ready) quiet = 1'b0;
        end
        check("midrst.no_partial", 32'(quiet), 32'd1);
        transact(8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 0, 1'b0, "postrst");

        // Randomized operands with random DONE stalls and idle gaps
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            model(ra, rb, es, ec, eo);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            transact(ra, rb, es, ec, eo, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
